serial_scan_arbiter: RTL

Round-robin scheduler that shares one serial "01" pattern-detector engine between `NREQ` requesters. The scheduler grants one requester and latches its parallel word. It then streams the word LSB-first through the detector, counts every 0→1 bit pair, and returns the count tagged with the requester index. It sits between the parallel requester ports and the single Moore pattern-detect FSM.

---
 rtl/scan_pkg.sv | 17 +
 rtl/pattern01_detector.sv | 39 +++
 rtl/serial_scan_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared state encodings for the serial scan arbiter and its "01" detector.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } det_state_t;

endpackage

// File: rtl/pattern01_detector.sv
// Moore detector for the serial bit pattern "01"; y is high in the state reached by a 0 followed by a 1.
module pattern01_detector
  import scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic a,
  output logic y
);

  det_state_t state_q;
  det_state_t state_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  // Next state: clear wins over enable; the unused encoding falls back to S0
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else begin
      case (state_q)
        S0:      if (en) state_d = a ? S0 : S1;
        S1:      if (en) state_d = a ? S2 : S1;
        S2:      if (en) state_d = a ? S0 : S1;
        default: state_d = S0;
      endcase
    end
  end

  assign y = (state_q == S2);

endmodule

// File: rtl/serial_scan_arbiter.sv
// Round-robin scheduler feeding one serial "01" detector; returns per-word match counts tagged with the requester index.
module serial_scan_arbiter
  import scan_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = $clog2(NREQ),
  parameter int unsigned CW    = $clog2(WIDTH + 1)
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [CW-1:0]           match_count
);

  localparam int unsigned BW = $clog2(WIDTH);

  ctrl_state_t     state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_d;
  logic            busy_d, done_d;
  logic [IDW-1:0]  done_id_d;
  logic [CW-1:0]   match_count_d;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  int unsigned     rr_sum;
  logic            det_clr, det_en, det_y;

  pattern01_detector u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .en    (det_en),
    .a     (word_q[0]),
    .y     (det_y)
  );

  // Round-robin pick: first requester at or after the priority pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      rr_sum = 32'(ptr_q) + off;
      if (rr_sum >= NREQ) rr_sum = rr_sum - NREQ;
      if (!win_found && req[IDW'(rr_sum)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(rr_sum);
      end
    end
  end

  // Controller next state and next values of every registered output
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    word_d        = word_q;
    bit_d         = bit_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    gnt_d         = '0;
    busy_d        = busy;
    done_d        = 1'b0;
    done_id_d     = done_id;
    match_count_d = match_count;
    det_clr       = 1'b0;
    det_en        = 1'b0;

    case (state_q)
      IDLE: begin
        det_clr = 1'b1;
        if (win_found) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_idx) word_d = data[i*WIDTH +: WIDTH];
          end
          id_d           = win_idx;
          bit_d          = '0;
          cnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          busy_d         = 1'b1;
          ptr_d          = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          state_d        = SHIFT;
        end
      end
      SHIFT: begin
        det_en = 1'b1;
        cnt_d  = cnt_q + CW'(det_y);
        word_d = word_q >> 1;
        bit_d  = bit_q + BW'(1);
        if (bit_q == BW'(WIDTH - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        // Detector output for the last bit is visible only now
        cnt_d         = cnt_q + CW'(det_y);
        match_count_d = cnt_q + CW'(det_y);
        done_id_d     = id_q;
        done_d        = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      word_q      <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      match_count <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      word_q      <= word_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      gnt         <= gnt_d;
      busy        <= busy_d;
      done        <= done_d;
      done_id     <= done_id_d;
      match_count <= match_count_d;
    end
  end

endmodule
